// File: rtl/feature_deserializer_pkg.sv
// Shared constants and FSM state type for the feature deserializer.
// Frame geometry: channels per frame, bits per channel, lanes per beat.
package feature_deserializer_pkg;

  localparam int TOTAL_NUM_CHANNEL = 214;
  localparam int CHANNEL_WIDTH = 2;
  localparam int FEAT_LANES = 4;
  localparam int BEATS =
    (TOTAL_NUM_CHANNEL + FEAT_LANES - 1) / FEAT_LANES;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    DROP    = 2'd2
  } fd_state_t;

endpackage

// File: rtl/feature_frame_slot.sv
// Output holding register with valid/ready handshake.
// Ports: load/load_data fill the slot; valid/data/ready face the core.
module feature_frame_slot
  import feature_deserializer_pkg::*;
#(
  parameter int W = TOTAL_NUM_CHANNEL * CHANNEL_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A load in the same cycle as an accept keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/feature_deserializer.sv
// Assembles FEAT_LANES-wide feature beats into one frame for the core.
// Ports: sin_* stream in, fin_*/features_top frame out, frame_err/err_count.
module feature_deserializer #(
  parameter int TOTAL_NUM_CHANNEL =
    feature_deserializer_pkg::TOTAL_NUM_CHANNEL,
  parameter int CHANNEL_WIDTH =
    feature_deserializer_pkg::CHANNEL_WIDTH,
  parameter int FEAT_LANES =
    feature_deserializer_pkg::FEAT_LANES
) (
  input  logic clk,
  input  logic rst,
  input  logic sin_valid,
  output logic sin_ready,
  input  logic [FEAT_LANES*CHANNEL_WIDTH-1:0] sin_data,
  input  logic sin_last,
  output logic fin_valid,
  input  logic fin_ready,
  output logic [TOTAL_NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
  output logic frame_err,
  output logic [7:0] err_count
);

  import feature_deserializer_pkg::*;

  localparam int NBEATS =
    (TOTAL_NUM_CHANNEL + FEAT_LANES - 1) / FEAT_LANES;
  localparam int CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int FW = TOTAL_NUM_CHANNEL * CHANNEL_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  fd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0]    asm_q, asm_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic accept;
  logic slot_load;
  logic slot_valid;

  // Held low during reset so nothing is taken before the FSM runs.
  assign sin_ready = rst && (state_q != FULL);
  assign accept    = sin_valid && sin_ready;
  assign slot_load = (state_q == FULL) && (!slot_valid || fin_ready);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = sin_last ? FULL : DROP;
            err_d   = !sin_last;
          end else if (sin_last) begin
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DROP: begin
        if (accept && sin_last) state_d = COLLECT;
      end
      FULL: begin
        if (slot_load) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Channel 0 lives at the MSBs; lanes past the last channel are dropped.
  always_comb begin
    asm_d = asm_q;
    if (accept && (state_q == COLLECT)) begin
      for (int j = 0; j < FEAT_LANES; j++) begin
        if (int'(cnt_q) * FEAT_LANES + j < TOTAL_NUM_CHANNEL) begin
          asm_d[(TOTAL_NUM_CHANNEL - 1 - (int'(cnt_q) * FEAT_LANES + j))
                * CHANNEL_WIDTH +: CHANNEL_WIDTH] =
            sin_data[j*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      asm_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  feature_frame_slot #(
    .W(FW)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .load_data (asm_q),
    .ready     (fin_ready),
    .valid     (slot_valid),
    .data      (features_top)
  );

  assign fin_valid = slot_valid;
  assign frame_err = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_feature_deserializer.sv
// Randomized self-checking bench for feature_deserializer.
// Frames are modelled as channel arrays; expected vectors built from them.
module tb_feature_deserializer;
  import feature_deserializer_pkg::*;

  localparam int TC = TOTAL_NUM_CHANNEL;
  localparam int CW = CHANNEL_WIDTH;
  localparam int FL = FEAT_LANES;
  localparam int NB = BEATS;
  localparam int W  = TC * CW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sin_valid = 1'b0;
  logic sin_ready;
  logic [FL*CW-1:0] sin_data = '0;
  logic sin_last = 1'b0;
  logic fin_valid;
  logic fin_ready = 1'b0;
  logic [W-1:0] features_top;
  logic frame_err;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  feature_deserializer dut (
    .clk          (clk),
    .rst          (rst),
    .sin_valid    (sin_valid),
    .sin_ready    (sin_ready),
    .sin_data     (sin_data),
    .sin_last     (sin_last),
    .fin_valid    (fin_valid),
    .fin_ready    (fin_ready),
    .features_top (features_top),
    .frame_err    (frame_err),
    .err_count    (err_count)
  );

  int checks = 0;
  int passed = 0;

  logic [1:0] cur [TC];
  logic [W-1:0] got_q [$];
  int err_pulses = 0;
  int exp_err = 0;
  bit last_acc = 0;
  bit rand_ready = 0;
  bit gaps = 0;
  bit [7:0] vhist = '0;

  function automatic logic [W-1:0] frame_vec();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < TC; k++) v[(TC-k)*CW-1 -: CW] = cur[k];
    return v;
  endfunction

  function automatic logic [7:0] exp_cnt();
    return (exp_err > 255) ? 8'd255 : 8'(exp_err);
  endfunction

  task automatic fill_mod4();
    for (int k = 0; k < TC; k++) cur[k] = 2'(k % 4);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < TC; k++) cur[k] = 2'($urandom);
  endtask

  task automatic cycle();
    @(negedge clk);
    last_acc = sin_valid && sin_ready;
    vhist = {vhist[6:0], fin_valid};
    if (fin_valid && fin_ready) got_q.push_back(features_top);
    if (frame_err) err_pulses++;
    @(posedge clk);
    #1;
    if (rand_ready) fin_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic send_beats(input int n, input int last_at,
                            input bit junk11);
    int ch;
    int t;
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          sin_valid = 1'b0;
          sin_data = FL*CW'($urandom);
          cycle();
        end
      end
      sin_valid = 1'b1;
      sin_last = (b == last_at);
      for (int j = 0; j < FL; j++) begin
        ch = b * FL + j;
        if (ch < TC) sin_data[j*CW +: CW] = cur[ch];
        else if (junk11) sin_data[j*CW +: CW] = 2'b11;
        else sin_data[j*CW +: CW] = 2'($urandom);
      end
      t = 0;
      do begin
        cycle();
        t++;
      end while (!last_acc && t < 300);
      if (!last_acc) begin
        checks++;
        $display("FAIL beat_accept_timeout: beat %0d not taken", b);
      end
    end
    sin_valid = 1'b0;
    sin_last = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (got_q.size() < n && t < budget) begin
      cycle();
      t++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({sin_ready, fin_valid, frame_err, err_count} !== 11'd0)
      $display("FAIL reset_ctrl: got %b want 0",
               {sin_ready, fin_valid, frame_err, err_count});
    else passed++;
    checks++;
    if (features_top !== '0)
      $display("FAIL reset_data: got %h want 0", features_top);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sin_ready !== 1'b1)
      $display("FAIL ready_after_reset: got %b want 1", sin_ready);
    else passed++;
    exp_err = 0;
  endtask

  task automatic test_single();
    logic [W-1:0] e;
    fill_mod4();
    e = frame_vec();
    fin_ready = 1'b1;
    send_beats(NB, NB - 1, 1'b0);
    @(negedge clk);
    checks++;
    if (fin_valid !== 1'b0)
      $display("FAIL single_latency_t1: got %b want 0", fin_valid);
    else passed++;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (fin_valid !== 1'b1)
      $display("FAIL single_latency_t2: got %b want 1", fin_valid);
    else passed++;
    checks++;
    if (features_top[W-1 -: 2] !== 2'b00)
      $display("FAIL single_ch0: got %b want 00", features_top[W-1 -: 2]);
    else passed++;
    checks++;
    if (features_top[1:0] !== 2'b01)
      $display("FAIL single_ch213: got %b want 01", features_top[1:0]);
    else passed++;
    checks++;
    if (features_top[3:2] !== 2'b00)
      $display("FAIL single_ch212: got %b want 00", features_top[3:2]);
    else passed++;
    checks++;
    if (features_top !== e)
      $display("FAIL single_frame: got %h want %h", features_top, e);
    else passed++;
    checks++;
    if (err_count !== 8'd0)
      $display("FAIL single_errcnt: got %0d want 0", err_count);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a;
    logic [W-1:0] b;
    int bad;
    fin_ready = 1'b0;
    got_q.delete();
    fill_rand();
    a = frame_vec();
    send_beats(NB, NB - 1, 1'b0);
    fill_rand();
    b = frame_vec();
    send_beats(NB, NB - 1, 1'b0);
    bad = 0;
    for (int i = 0; i < 90; i++) begin
      cycle();
      if (!(fin_valid === 1'b1 && features_top === a
            && sin_ready === 1'b0)) bad++;
    end
    checks++;
    if (bad != 0)
      $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    else passed++;
    checks++;
    if (got_q.size() != 0)
      $display("FAIL bp_no_accept: got %0d frames want 0", got_q.size());
    else passed++;
    fin_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (vhist[2:0] !== 3'b110)
      $display("FAIL bp_no_gap: got %b want 110", vhist[2:0]);
    else passed++;
    checks++;
    if (got_q.size() != 2 || got_q[0] !== a || got_q[1] !== b)
      $display("FAIL bp_order: got %0d frames want 2 (A,B)", got_q.size());
    else passed++;
  endtask

  task automatic test_early_last();
    logic [W-1:0] g;
    fin_ready = 1'b1;
    got_q.delete();
    err_pulses = 0;
    fill_rand();
    send_beats(11, 10, 1'b0);
    exp_err++;
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (err_pulses != 1)
      $display("FAIL early_pulse: got %0d want 1", err_pulses);
    else passed++;
    checks++;
    if (err_count !== exp_cnt())
      $display("FAIL early_errcnt: got %0d want %0d", err_count, exp_cnt());
    else passed++;
    checks++;
    if (got_q.size() != 0)
      $display("FAIL early_no_out: got %0d want 0", got_q.size());
    else passed++;
    fill_rand();
    g = frame_vec();
    send_beats(NB, NB - 1, 1'b0);
    wait_frames(1, 10);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== g)
      $display("FAIL early_next_frame: got %0d frames want 1 matching",
               got_q.size());
    else passed++;
  endtask

  task automatic test_missing_last();
    logic [W-1:0] g;
    fin_ready = 1'b1;
    got_q.delete();
    err_pulses = 0;
    fill_rand();
    send_beats(NB + 5, NB + 4, 1'b0);
    exp_err++;
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (err_pulses != 1)
      $display("FAIL missing_pulse: got %0d want 1", err_pulses);
    else passed++;
    checks++;
    if (err_count !== exp_cnt())
      $display("FAIL missing_errcnt: got %0d want %0d", err_count, exp_cnt());
    else passed++;
    checks++;
    if (got_q.size() != 0)
      $display("FAIL missing_no_out: got %0d want 0", got_q.size());
    else passed++;
    fill_rand();
    g = frame_vec();
    send_beats(NB, NB - 1, 1'b0);
    wait_frames(1, 10);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== g)
      $display("FAIL missing_next_frame: got %0d frames want 1 matching",
               got_q.size());
    else passed++;
  endtask

  task automatic test_final_lanes();
    logic [W-1:0] g;
    fin_ready = 1'b1;
    got_q.delete();
    fill_rand();
    g = frame_vec();
    send_beats(NB, NB - 1, 1'b1);
    wait_frames(1, 10);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== g)
      $display("FAIL final_lanes: got %0d frames want 1 matching",
               got_q.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q [$];
    got_q.delete();
    gaps = 1;
    rand_ready = 1;
    for (int f = 0; f < 6; f++) begin
      fill_rand();
      exp_q.push_back(frame_vec());
      send_beats(NB, NB - 1, 1'b0);
    end
    gaps = 0;
    rand_ready = 0;
    fin_ready = 1'b1;
    wait_frames(6, 200);
    checks++;
    if (got_q.size() != 6)
      $display("FAIL b2b_count: got %0d want 6", got_q.size());
    else passed++;
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (got_q.size() <= f || got_q[f] !== exp_q[f])
        $display("FAIL b2b_frame%0d: got mismatch want model frame", f);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] g;
    int la;
    fin_ready = 1'b1;
    got_q.delete();
    err_pulses = 0;
    exp_err = 0;
    // err_count still holds earlier errors; model them first.
    exp_err = 2;
    for (int f = 0; f < 300; f++) begin
      fill_rand();
      la = $urandom_range(0, NB - 2);
      send_beats(la + 1, la, 1'b0);
      exp_err++;
      if (f == 252) begin
        cycle();
        checks++;
        if (err_count !== exp_cnt())
          $display("FAIL sat_reach: got %0d want %0d", err_count, exp_cnt());
        else passed++;
      end
    end
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (err_count !== 8'd255)
      $display("FAIL sat_hold: got %0d want 255", err_count);
    else passed++;
    checks++;
    if (err_pulses != 300)
      $display("FAIL sat_pulses: got %0d want 300", err_pulses);
    else passed++;
    fill_rand();
    g = frame_vec();
    send_beats(NB, NB - 1, 1'b0);
    wait_frames(1, 10);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== g)
      $display("FAIL sat_next_frame: got %0d frames want 1 matching",
               got_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] g;
    fin_ready = 1'b0;
    got_q.delete();
    fill_rand();
    send_beats(NB, NB - 1, 1'b0);
    fill_rand();
    send_beats(20, -1, 1'b0);
    cycle();
    #2;
    rst = 1'b0;
    #2;
    checks++;
    if ({sin_ready, fin_valid, frame_err, err_count} !== 11'd0)
      $display("FAIL midreset_ctrl: got %b want 0",
               {sin_ready, fin_valid, frame_err, err_count});
    else passed++;
    checks++;
    if (features_top !== '0)
      $display("FAIL midreset_data: got %h want 0", features_top);
    else passed++;
    exp_err = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    fin_ready = 1'b1;
    got_q.delete();
    err_pulses = 0;
    fill_rand();
    g = frame_vec();
    send_beats(NB, NB - 1, 1'b0);
    wait_frames(1, 10);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== g)
      $display("FAIL midreset_frame: got %0d frames want 1 matching",
               got_q.size());
    else passed++;
    checks++;
    if (err_pulses != 0 || err_count !== 8'd0)
      $display("FAIL midreset_err: got %0d/%0d want 0/0",
               err_pulses, err_count);
    else passed++;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_final_lanes();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
